// File: rtl/sha256_w_schedule_if.sv
// Word stream from the SHA-256 schedule generator to the compression rounds.
// valid/ready handshake; the source holds word and index stable until accepted.
interface sha256_w_schedule_if;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_out;
    logic [5:0]  w_index;

    modport master (output w_valid, output w_out, output w_index, input w_ready);
    modport slave  (input w_valid, input w_out, input w_index, output w_ready);
endinterface

// File: rtl/sha256_w_schedule.sv
// SHA-256 message schedule: loads one 512-bit block on enable, streams W[0..63].
// W[0] valid one cycle after load; one word per cycle; w_ready low freezes the window.
module sha256_w_schedule #(
    parameter int WORDS = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [511:0]               block_in,
    sha256_w_schedule_if.master        w,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, PARK} state_t;

    state_t      state_q;
    logic [31:0] win_q [16];
    logic [5:0]  t_q;

    logic [31:0] w16_d;
    logic        xfer_d;
    logic        last_d;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win_q[0] is W[t], so the window taps are W[t+14], W[t+9], W[t+1], W[t]
    assign w16_d  = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    assign xfer_d = (state_q == RUN) && w.w_ready;
    assign last_d = (t_q == 6'(WORDS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        for (int i = 0; i < 16; i++) begin
                            win_q[i] <= block_in[511 - 32*i -: 32];
                        end
                        t_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (xfer_d) begin
                        if (last_d) begin
                            t_q     <= '0;
                            state_q <= DONE;
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                win_q[i] <= win_q[i+1];
                            end
                            win_q[15] <= w16_d;
                            t_q       <= t_q + 6'd1;
                        end
                    end
                end
                // enable is sticky upstream; park until it drops so one assertion yields one block
                DONE: state_q <= enable ? PARK : IDLE;
                PARK: if (!enable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w.w_valid = (state_q == RUN);
    assign w.w_out   = win_q[0];
    assign w.w_index = t_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
